// File: rtl/lc3_mem_responder.sv
// Instruction/data memory responder for the LC3 core.
// It has two independent single-outstanding channels with configurable latency,
// and a backdoor preload port that the bench uses to place programs in memory.
module lc3_mem_responder #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned INSTR_LAT = 1,
  parameter int unsigned DATA_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic        data_req,
  input  logic [15:0] Data_addr,
  input  logic        Data_rd,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic        load_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [15:0] mem [0:(1 << ADDR_W) - 1];

  state_t            i_state, i_state_nxt;
  state_t            d_state, d_state_nxt;
  logic [3:0]        i_cnt, d_cnt;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic              d_rd;
  logic [15:0]       d_din;
  logic              i_accept, i_done, d_accept, d_done, load_ok;

  // Upper address bits alias onto the array and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc, Data_addr, load_addr};

  // Instruction channel next state; a request seen on the completion edge is
  // accepted immediately so that throughput stays at one access per latency.
  always_comb begin
    i_state_nxt = i_state;
    i_accept    = 1'b0;
    i_done      = 1'b0;
    case (i_state)
      IDLE: begin
        if (instrmem_rd) begin
          i_accept    = 1'b1;
          i_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (i_cnt == '0) begin
          i_done = 1'b1;
          if (instrmem_rd) i_accept = 1'b1;
          else             i_state_nxt = IDLE;
        end
      end
      default: i_state_nxt = IDLE;
    endcase
  end

  // Data channel next state; this channel follows the same scheme as the instruction channel.
  always_comb begin
    d_state_nxt = d_state;
    d_accept    = 1'b0;
    d_done      = 1'b0;
    case (d_state)
      IDLE: begin
        if (data_req) begin
          d_accept    = 1'b1;
          d_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (d_cnt == '0) begin
          d_done = 1'b1;
          if (data_req) d_accept = 1'b1;
          else          d_state_nxt = IDLE;
        end
      end
      default: d_state_nxt = IDLE;
    endcase
  end

  // A backdoor load is only safe when neither channel can touch the array.
  always_comb begin
    load_ok = load_en && (i_state == IDLE) && (d_state == IDLE) &&
              !instrmem_rd && !data_req;
  end

  // State registers for both channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_state <= IDLE;
      d_state <= IDLE;
    end else begin
      i_state <= i_state_nxt;
      d_state <= d_state_nxt;
    end
  end

  // Instruction datapath: capture the request, count down, and return the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_cnt          <= '0;
      i_addr         <= '0;
      Instr_dout     <= '0;
      complete_instr <= 1'b0;
    end else begin
      complete_instr <= i_done;
      if (i_done) Instr_dout <= mem[i_addr];
      if (i_accept) begin
        i_addr <= pc[ADDR_W-1:0];
        i_cnt  <= 4'(INSTR_LAT - 1);
      end else if (i_cnt != '0) begin
        i_cnt <= i_cnt - 4'd1;
      end
    end
  end

  // Data datapath: capture the request, count down, and return data on reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_cnt         <= '0;
      d_addr        <= '0;
      d_rd          <= 1'b0;
      d_din         <= '0;
      Data_dout     <= '0;
      complete_data <= 1'b0;
    end else begin
      complete_data <= d_done;
      if (d_done && d_rd) Data_dout <= mem[d_addr];
      if (d_accept) begin
        d_addr <= Data_addr[ADDR_W-1:0];
        d_rd   <= Data_rd;
        d_din  <= Data_din;
        d_cnt  <= 4'(DATA_LAT - 1);
      end else if (d_cnt != '0) begin
        d_cnt <= d_cnt - 4'd1;
      end
    end
  end

  // Array write port. This block has no reset, so memory contents persist through reset.
  // Reset still blocks a pending write from committing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (d_done && !d_rd)
        mem[d_addr] <= d_din;
      else if (load_ok)
        mem[load_addr[ADDR_W-1:0]] <= load_data;
    end
  end

  // Flag a rejected backdoor load one cycle later.
  always_ff @(posedge clk) begin
    if (reset) load_err <= 1'b0;
    else       load_err <= load_en && !load_ok;
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder. Instance a uses latency 1/1; instance b uses 3/3.
module tb_lc3_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rd_a, ci_a, dreq_a, drd_a, cd_a, len_a, lerr_a;
  logic [15:0] pc_a, idout_a, daddr_a, ddin_a, ddout_a, laddr_a, ldata_a;
  logic rst_b, rd_b, ci_b, dreq_b, drd_b, cd_b, len_b, lerr_b;
  logic [15:0] pc_b, idout_b, daddr_b, ddin_b, ddout_b, laddr_b, ldata_b;

  lc3_mem_responder #(.ADDR_W(12), .INSTR_LAT(1), .DATA_LAT(1)) dut_a (
    .clk(clk), .reset(rst_a), .pc(pc_a), .instrmem_rd(rd_a),
    .Instr_dout(idout_a), .complete_instr(ci_a), .data_req(dreq_a),
    .Data_addr(daddr_a), .Data_rd(drd_a), .Data_din(ddin_a),
    .Data_dout(ddout_a), .complete_data(cd_a), .load_en(len_a),
    .load_addr(laddr_a), .load_data(ldata_a), .load_err(lerr_a));

  lc3_mem_responder #(.ADDR_W(12), .INSTR_LAT(3), .DATA_LAT(3)) dut_b (
    .clk(clk), .reset(rst_b), .pc(pc_b), .instrmem_rd(rd_b),
    .Instr_dout(idout_b), .complete_instr(ci_b), .data_req(dreq_b),
    .Data_addr(daddr_b), .Data_rd(drd_b), .Data_din(ddin_b),
    .Data_dout(ddout_b), .complete_data(cd_b), .load_en(len_b),
    .load_addr(laddr_b), .load_data(ldata_b), .load_err(lerr_b));

  typedef struct {
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t qia[$], qda[$], qib[$], qdb[$];
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;
  logic [15:0] last_a = '0;
  logic [15:0] last_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors sample on the falling edge.
  always @(negedge clk) if (ci_a) begin
    total++;
    if (qia.size() == 0) begin
      bad++; $display("FAIL instr_a_spurious: got data=%h at cyc=%0d, expected no completion", idout_a, cyc);
    end else begin
      if (idout_a !== qia[0].data || cyc != qia[0].cyc) begin
        bad++; $display("FAIL instr_a: got data=%h cyc=%0d, expected data=%h cyc=%0d", idout_a, cyc, qia[0].data, qia[0].cyc);
      end
      void'(qia.pop_front());
    end
  end

  always @(negedge clk) if (cd_a) begin
    total++;
    if (qda.size() == 0) begin
      bad++; $display("FAIL data_a_spurious: got data=%h at cyc=%0d, expected no completion", ddout_a, cyc);
    end else begin
      if (ddout_a !== qda[0].data || cyc != qda[0].cyc) begin
        bad++; $display("FAIL data_a: got data=%h cyc=%0d, expected data=%h cyc=%0d", ddout_a, cyc, qda[0].data, qda[0].cyc);
      end
      void'(qda.pop_front());
    end
  end

  always @(negedge clk) if (ci_b) begin
    total++;
    if (qib.size() == 0) begin
      bad++; $display("FAIL instr_b_spurious: got data=%h at cyc=%0d, expected no completion", idout_b, cyc);
    end else begin
      if (idout_b !== qib[0].data || cyc != qib[0].cyc) begin
        bad++; $display("FAIL instr_b: got data=%h cyc=%0d, expected data=%h cyc=%0d", idout_b, cyc, qib[0].data, qib[0].cyc);
      end
      void'(qib.pop_front());
    end
  end

  always @(negedge clk) if (cd_b) begin
    total++;
    if (qdb.size() == 0) begin
      bad++; $display("FAIL data_b_spurious: got data=%h at cyc=%0d, expected no completion", ddout_b, cyc);
    end else begin
      if (ddout_b !== qdb[0].data || cyc != qdb[0].cyc) begin
        bad++; $display("FAIL data_b: got data=%h cyc=%0d, expected data=%h cyc=%0d", ddout_b, cyc, qdb[0].data, qdb[0].cyc);
      end
      void'(qdb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    rd_a = 0; dreq_a = 0; len_a = 0;
    rd_b = 0; dreq_b = 0; len_b = 0;
  endtask

  // The request is accepted at the next edge and completes LAT edges later.
  task automatic fetch_start(input bit sel, input logic [15:0] addr, input logic [15:0] exp);
    if (!sel) begin pc_a = addr; rd_a = 1; qia.push_back('{exp, cyc + 2}); end
    else      begin pc_b = addr; rd_b = 1; qib.push_back('{exp, cyc + 4}); end
  endtask

  task automatic dwrite_start(input bit sel, input logic [15:0] addr, input logic [15:0] val);
    if (!sel) begin daddr_a = addr; drd_a = 0; ddin_a = val; dreq_a = 1; qda.push_back('{last_a, cyc + 2}); end
    else      begin daddr_b = addr; drd_b = 0; ddin_b = val; dreq_b = 1; qdb.push_back('{last_b, cyc + 4}); end
  endtask

  task automatic dread_start(input bit sel, input logic [15:0] addr, input logic [15:0] exp);
    if (!sel) begin daddr_a = addr; drd_a = 1; dreq_a = 1; qda.push_back('{exp, cyc + 2}); last_a = exp; end
    else      begin daddr_b = addr; drd_b = 1; dreq_b = 1; qdb.push_back('{exp, cyc + 4}); last_b = exp; end
  endtask

  task automatic load(input bit sel, input logic [15:0] addr, input logic [15:0] val);
    if (!sel) begin laddr_a = addr; ldata_a = val; len_a = 1; end
    else      begin laddr_b = addr; ldata_b = val; len_b = 1; end
    tick();
    clear_reqs();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((qia.size() + qda.size() + qib.size() + qdb.size()) != 0 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if ((qia.size() + qda.size() + qib.size() + qdb.size()) != 0) begin
      bad++;
      $display("FAIL %s_timeout: %0d completions outstanding, expected 0", name,
               qia.size() + qda.size() + qib.size() + qdb.size());
      qia.delete(); qda.delete(); qib.delete(); qdb.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_a = 1; rst_b = 1;
    tick(); tick();
    total += 8;
    if (ci_a !== 1'b0)       begin bad++; $display("FAIL reset_ci_a: got %b, expected 0", ci_a); end
    if (cd_a !== 1'b0)       begin bad++; $display("FAIL reset_cd_a: got %b, expected 0", cd_a); end
    if (idout_a !== 16'h0)   begin bad++; $display("FAIL reset_idout_a: got %h, expected 0000", idout_a); end
    if (ddout_a !== 16'h0)   begin bad++; $display("FAIL reset_ddout_a: got %h, expected 0000", ddout_a); end
    if (lerr_a !== 1'b0)     begin bad++; $display("FAIL reset_lerr_a: got %b, expected 0", lerr_a); end
    if (ci_b !== 1'b0)       begin bad++; $display("FAIL reset_ci_b: got %b, expected 0", ci_b); end
    if (idout_b !== 16'h0)   begin bad++; $display("FAIL reset_idout_b: got %h, expected 0000", idout_b); end
    if (ddout_b !== 16'h0)   begin bad++; $display("FAIL reset_ddout_b: got %h, expected 0000", ddout_b); end
    rst_a = 0; rst_b = 0;
    tick();
  endtask

  task automatic test_fetch_lat1();
    load(0, 16'h3000, 16'h1234);
    fetch_start(0, 16'h3000, 16'h1234);
    tick(); clear_reqs();
    wait_drain("fetch_lat1");
  endtask

  task automatic test_fetch_lat3();
    load(1, 16'h3001, 16'hA5A5);
    load(1, 16'h3002, 16'h0F0F);
    fetch_start(1, 16'h3001, 16'hA5A5);
    tick(); clear_reqs();
    pc_b = 16'h3002;
    wait_drain("fetch_lat3");
  endtask

  task automatic test_write_read();
    dwrite_start(0, 16'h0040, 16'hBEEF);
    tick(); clear_reqs();
    wait_drain("write");
    dread_start(0, 16'h0040, 16'hBEEF);
    tick(); clear_reqs();
    wait_drain("read");
    total++;
    if (ddout_a !== 16'hBEEF) begin bad++; $display("FAIL read_hold: got %h, expected beef", ddout_a); end
  endtask

  task automatic test_same_edge();
    fetch_start(0, 16'h0040, 16'hBEEF);
    dwrite_start(0, 16'h0040, 16'h5555);
    tick(); clear_reqs();
    wait_drain("same_edge");
    fetch_start(0, 16'h0040, 16'h5555);
    tick(); clear_reqs();
    wait_drain("same_edge_refetch");
  endtask

  task automatic test_back_to_back();
    int unsigned k = cyc;
    pc_b = 16'h3001; rd_b = 1;
    qib.push_back('{16'hA5A5, k + 4});
    qib.push_back('{16'h0F0F, k + 7});
    qib.push_back('{16'hA5A5, k + 10});
    for (int i = 1; i <= 7; i++) begin
      tick();
      pc_b = (i == 3) ? 16'h3002 : 16'h3001;
    end
    clear_reqs();
    wait_drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    load(1, 16'h0010, 16'h1111);
    daddr_b = 16'h0010; drd_b = 0; ddin_b = 16'h7777; dreq_b = 1;
    tick(); clear_reqs();
    rst_b = 1;
    tick(); tick();
    rst_b = 0;
    last_b = '0;
    total += 4;
    if (ci_b !== 1'b0)     begin bad++; $display("FAIL rstmid_ci: got %b, expected 0", ci_b); end
    if (cd_b !== 1'b0)     begin bad++; $display("FAIL rstmid_cd: got %b, expected 0", cd_b); end
    if (idout_b !== 16'h0) begin bad++; $display("FAIL rstmid_idout: got %h, expected 0000", idout_b); end
    if (ddout_b !== 16'h0) begin bad++; $display("FAIL rstmid_ddout: got %h, expected 0000", ddout_b); end
    repeat (5) tick();
    dread_start(1, 16'h0010, 16'h1111);
    tick(); clear_reqs();
    wait_drain("rstmid_read");
  endtask

  task automatic test_load_err();
    load(0, 16'h0050, 16'h0ABC);
    dread_start(0, 16'h0050, 16'h0ABC);
    tick(); clear_reqs();
    laddr_a = 16'h1040; ldata_a = 16'h9999; len_a = 1;
    tick(); clear_reqs();
    total++;
    if (lerr_a !== 1'b1) begin bad++; $display("FAIL load_err_pulse: got %b, expected 1", lerr_a); end
    tick();
    total++;
    if (lerr_a !== 1'b0) begin bad++; $display("FAIL load_err_clear: got %b, expected 0", lerr_a); end
    wait_drain("load_err_read");
    fetch_start(0, 16'h0040, 16'h5555);
    tick(); clear_reqs();
    wait_drain("load_err_unchanged");
    load(0, 16'h1040, 16'h6666);
    total++;
    if (lerr_a !== 1'b0) begin bad++; $display("FAIL load_ok_noerr: got %b, expected 0", lerr_a); end
    fetch_start(0, 16'h0040, 16'h6666);
    tick(); clear_reqs();
    wait_drain("load_alias");
  endtask

  initial begin
    rst_a = 1; rst_b = 1;
    pc_a = '0; daddr_a = '0; drd_a = 0; ddin_a = '0; laddr_a = '0; ldata_a = '0;
    pc_b = '0; daddr_b = '0; drd_b = 0; ddin_b = '0; laddr_b = '0; ldata_b = '0;
    clear_reqs();
    test_reset();
    test_fetch_lat1();
    test_fetch_lat3();
    test_write_read();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();
    test_load_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
